// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU and load/MUL write requests, register-file write port, decode forwarding.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                  alu_wr_valid;
    logic [REG_ADDR_W-1:0] alu_wr_rd;
    logic [XLEN-1:0]       alu_wr_data;
    logic                  mem_wr_valid;
    logic                  mem_wr_ready;
    logic [REG_ADDR_W-1:0] mem_wr_rd;
    logic [XLEN-1:0]       mem_wr_data;
    logic                  alu_stall;
    logic                  rf_reg_write;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_rd_data;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_fwd_hit;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic                  rs2_fwd_hit;
    logic [XLEN-1:0]       rs2_fwd_data;

    modport slave (
        input  alu_wr_valid, alu_wr_rd, alu_wr_data,
        input  mem_wr_valid, mem_wr_rd, mem_wr_data, rs1, rs2,
        output mem_wr_ready, alu_stall, rf_reg_write, rf_rd, rf_rd_data,
        output rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data
    );

    modport master (
        output alu_wr_valid, alu_wr_rd, alu_wr_data,
        output mem_wr_valid, mem_wr_rd, mem_wr_data, rs1, rs2,
        input  mem_wr_ready, alu_stall, rf_reg_write, rf_rd, rf_rd_data,
        input  rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data
    );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Pending load/MUL results: wrap-bit pointer FIFO with kill-by-rd and two newest-match lookups.
module wb_pending_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t             head,
    output logic                  rs1_hit,
    output logic [XLEN-1:0]       rs1_data,
    output logic                  rs2_hit,
    output logic [XLEN-1:0]       rs2_data
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] idx;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++)
            if (kill_en && mem_q[i].valid && mem_q[i].rd == kill_rd) mem_d[i].valid = 1'b0;
        if (pop) begin
            mem_d[rd_ptr_q[PW-1:0]].valid = 1'b0;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_entry;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
    end

    // Popped slots are invalidated, so only live entries carry valid; scanning oldest to
    // newest lets the youngest match overwrite older ones.
    always_comb begin
        rs1_hit  = 1'b0;
        rs1_data = '0;
        rs2_hit  = 1'b0;
        rs2_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q[PW-1:0] + PW'(k);
            if (mem_q[idx].valid && rs1 != '0 && mem_q[idx].rd == rs1) begin
                rs1_hit  = 1'b1;
                rs1_data = mem_q[idx].data;
            end
            if (mem_q[idx].valid && rs2 != '0 && mem_q[idx].rd == rs2) begin
                rs2_hit  = 1'b1;
                rs2_data = mem_q[idx].data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU first, pending load/MUL FIFO with bypass, WAW kill
// and a starvation guard that briefly stalls the ALU.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t head, push_entry;
    logic fifo_full, fifo_empty;
    logic alu_grant, mem_live, head_pop, silent_pop, bypass, push, head_live;

    logic                  alu_stall_q, alu_stall_d;
    logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
    logic                  rf_reg_write_q, rf_reg_write_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_rd_data_q, rf_rd_data_d;

    assign alu_grant  = !alu_stall_q && bus.alu_wr_valid && (bus.alu_wr_rd != '0);
    assign mem_live   = bus.mem_wr_valid && !fifo_full && (bus.mem_wr_rd != '0);
    assign head_pop   = !fifo_empty && head.valid && !alu_grant;
    assign silent_pop = !fifo_empty && !head.valid;
    assign bypass     = fifo_empty && !alu_grant && mem_live;
    assign push       = mem_live && !bypass;
    assign head_live  = !fifo_empty && head.valid && !(alu_grant && head.rd == bus.alu_wr_rd);
    // A same-cycle ALU write to the same rd supersedes the incoming entry.
    assign push_entry = '{valid: !(alu_grant && bus.mem_wr_rd == bus.alu_wr_rd),
                          rd: bus.mem_wr_rd, data: bus.mem_wr_data};

    wb_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (head_pop || silent_pop),
        .kill_en   (alu_grant),
        .kill_rd   (bus.alu_wr_rd),
        .rs1       (bus.rs1),
        .rs2       (bus.rs2),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head),
        .rs1_hit   (bus.rs1_fwd_hit),
        .rs1_data  (bus.rs1_fwd_data),
        .rs2_hit   (bus.rs2_fwd_hit),
        .rs2_data  (bus.rs2_fwd_data)
    );

    always_comb begin
        rf_reg_write_d = 1'b0;
        rf_rd_d        = rf_rd_q;
        rf_rd_data_d   = rf_rd_data_q;
        if (alu_grant) begin
            rf_reg_write_d = 1'b1;
            rf_rd_d        = bus.alu_wr_rd;
            rf_rd_data_d   = bus.alu_wr_data;
        end else if (head_pop) begin
            rf_reg_write_d = 1'b1;
            rf_rd_d        = head.rd;
            rf_rd_data_d   = head.data;
        end else if (bypass) begin
            rf_reg_write_d = 1'b1;
            rf_rd_d        = bus.mem_wr_rd;
            rf_rd_data_d   = bus.mem_wr_data;
        end
    end

    // One-cycle stall once the live head has lost STARVE_LIMIT times in a row.
    always_comb begin
        alu_stall_d  = 1'b0;
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || head_pop || silent_pop) begin
            starve_cnt_d = '0;
        end else if (alu_grant && head_live) begin
            if (starve_cnt_q == CW'(STARVE_LIMIT - 1)) begin
                alu_stall_d  = 1'b1;
                starve_cnt_d = '0;
            end else begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_stall_q    <= 1'b0;
            starve_cnt_q   <= '0;
            rf_reg_write_q <= 1'b0;
            rf_rd_q        <= '0;
            rf_rd_data_q   <= '0;
        end else begin
            alu_stall_q    <= alu_stall_d;
            starve_cnt_q   <= starve_cnt_d;
            rf_reg_write_q <= rf_reg_write_d;
            rf_rd_q        <= rf_rd_d;
            rf_rd_data_q   <= rf_rd_data_d;
        end
    end

    assign bus.mem_wr_ready = !fifo_full;
    assign bus.alu_stall    = alu_stall_q;
    assign bus.rf_reg_write = rf_reg_write_q;
    assign bus.rf_rd        = rf_rd_q;
    assign bus.rf_rd_data   = rf_rd_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus random traffic, checked against a queue-based writeback model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();
    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        bit          valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t       q[$];
    bit          m_stall, m_we;
    int          m_cnt;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_stall = 0; m_we = 0; m_cnt = 0; m_rd = '0; m_data = '0;
    endtask

    function automatic void model_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0; d = '0;
        if (rs != 0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].valid && q[i].rd == rs) begin hit = 1'b1; d = q[i].data; break; end
    endfunction

    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.alu_wr_valid = av; bus.alu_wr_rd = ard; bus.alu_wr_data = ad;
        bus.mem_wr_valid = mv; bus.mem_wr_rd = mrd; bus.mem_wr_data = md;
        bus.rs1 = r1; bus.rs2 = r2;
    endtask

    // One cycle of the writeback rules applied to the pending list.
    task automatic model_step();
        bit ag, live, empty0, hv0, popped, hlive;
        ment_t e;
        empty0 = (q.size() == 0);
        hv0    = !empty0 && q[0].valid;
        ag     = !m_stall && bus.alu_wr_valid && bus.alu_wr_rd != 0;
        live   = bus.mem_wr_valid && q.size() < DEPTH && bus.mem_wr_rd != 0;
        m_we   = 0;
        if (ag) begin m_we = 1; m_rd = bus.alu_wr_rd; m_data = bus.alu_wr_data; end
        else if (hv0) begin m_we = 1; m_rd = q[0].rd; m_data = q[0].data; end
        else if (empty0 && live) begin m_we = 1; m_rd = bus.mem_wr_rd; m_data = bus.mem_wr_data; end
        if (ag) foreach (q[i]) if (q[i].rd == bus.alu_wr_rd) q[i].valid = 0;
        hlive  = ag && !empty0 && q[0].valid;
        popped = !empty0 && (!hv0 || !ag);
        if (popped) void'(q.pop_front());
        if (live && !(empty0 && !ag)) begin
            e.valid = !(ag && bus.mem_wr_rd == bus.alu_wr_rd);
            e.rd = bus.mem_wr_rd; e.data = bus.mem_wr_data;
            q.push_back(e);
        end
        m_stall = 0;
        if (popped || empty0) m_cnt = 0;
        else if (hlive) begin
            if (m_cnt == LIMIT - 1) begin m_stall = 1; m_cnt = 0; end
            else m_cnt++;
        end
    endtask

    task automatic pre(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
        logic h; logic [31:0] d;
        drive(av, ard, ad, mv, mrd, md, r1, r2);
        #1;
        chk("ready", bus.mem_wr_ready, q.size() < DEPTH);
        model_fwd(r1, h, d);
        chk("rs1_hit", bus.rs1_fwd_hit, h); chk("rs1_data", bus.rs1_fwd_data, d);
        model_fwd(r2, h, d);
        chk("rs2_hit", bus.rs2_fwd_hit, h); chk("rs2_data", bus.rs2_fwd_data, d);
        model_step();
    endtask

    task automatic post();
        @(posedge clk); #1;
        chk("alu_stall", bus.alu_stall, m_stall);
        chk("rf_we", bus.rf_reg_write, m_we);
        chk("rf_rd", bus.rf_rd, m_rd);
        chk("rf_data", bus.rf_rd_data, m_data);
    endtask

    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
        pre(av, ard, ad, mv, mrd, md, r1, r2);
        post();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk); #1;
        chk("rst_we", bus.rf_reg_write, 0); chk("rst_stall", bus.alu_stall, 0);
        chk("rst_rd", bus.rf_rd, 0); chk("rst_data", bus.rf_rd_data, 0);
        rst = 1'b0;

        // Solo load goes straight through
        cyc(0, 0, 0, 1, 5, 32'h55, 0, 0);
        chk("solo_we", bus.rf_reg_write, 1); chk("solo_rd", bus.rf_rd, 5);
        chk("solo_data", bus.rf_rd_data, 32'h55);

        // Conflict: ALU first, load buffered and forwarded
        cyc(1, 3, 7, 1, 4, 9, 0, 0);
        chk("conf_rd0", bus.rf_rd, 3);
        pre(0, 0, 0, 0, 0, 0, 4, 0);
        chk("conf_fwd_hit", bus.rs1_fwd_hit, 1); chk("conf_fwd_data", bus.rs1_fwd_data, 9);
        post();
        chk("conf_rd1", bus.rf_rd, 4); chk("conf_data1", bus.rf_rd_data, 9);

        // WAW kill of a buffered entry
        cyc(1, 1, 32'h11, 1, 6, 1, 0, 0);
        cyc(1, 6, 2, 0, 0, 0, 6, 0);
        chk("waw_rd", bus.rf_rd, 6); chk("waw_data", bus.rf_rd_data, 2);
        pre(0, 0, 0, 0, 0, 0, 6, 0);
        chk("waw_nohit", bus.rs1_fwd_hit, 0);
        post();
        chk("waw_nowrite", bus.rf_reg_write, 0);
        idle(1);

        // Starvation: stall after LIMIT blocked cycles, x7 drains during it
        for (int i = 0; i < 8; i++) begin
            cyc(1, 5'(1 + i % 3), 32'(100 + i), i == 0, 7, 32'hAA, 0, 0);
            if (i == 4) chk("starve_stall", bus.alu_stall, 1);
            if (i == 5) begin
                chk("starve_rd", bus.rf_rd, 7); chk("starve_data", bus.rf_rd_data, 32'hAA);
                chk("starve_unstall", bus.alu_stall, 0);
            end
        end
        idle(1);

        // Full FIFO, then rd==0 load is dropped
        cyc(1, 1, 1, 1, 9, 32'h99, 0, 0);
        cyc(1, 2, 2, 1, 10, 32'hA0, 9, 10);
        pre(1, 3, 3, 1, 0, 32'hDEAD, 0, 0);
        chk("full_ready", bus.mem_wr_ready, 0);
        post();
        idle(3);
        cyc(0, 0, 0, 1, 0, 32'hBEEF, 0, 0);
        chk("rd0_dropped", bus.rf_reg_write, 0);

        // Reset mid-fill discards pending writes
        cyc(1, 1, 1, 1, 12, 32'h12, 0, 0);
        cyc(1, 2, 2, 1, 13, 32'h13, 0, 0);
        drive(1, 3, 3, 1, 14, 32'h14, 12, 13);
        rst = 1'b1;
        #1;
        chk("rst2_we", bus.rf_reg_write, 0); chk("rst2_rd", bus.rf_rd, 0);
        chk("rst2_data", bus.rf_rd_data, 0); chk("rst2_ready", bus.mem_wr_ready, 1);
        chk("rst2_fwd", bus.rs1_fwd_hit, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 12, 13);
        chk("rst2_nowrite", bus.rf_reg_write, 0);

        // Random traffic with colliding register numbers
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, 5'($urandom % 8), $urandom,
                $urandom % 2, 5'($urandom % 8), $urandom,
                5'($urandom % 8), 5'($urandom % 8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
